mul_arbiter: RTL and testbench



---
 rtl/mul_arbiter.sv | 138 +++++++++++++
 tb/tb_mul_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter that shares one pipelined multiplier among
// NUM_REQ requesters. The originating requester index rides along in a tag
// shift register so each result can be routed back with its id.
module mul_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned DELAY      = 3,
  localparam int unsigned ID_WIDTH  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CNT_WIDTH = $clog2(DELAY + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  // request side
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  // response side
  output logic                            resp_valid,
  output logic [ID_WIDTH-1:0]             resp_id,
  output logic [OUT_WIDTH-1:0]            resp_data,
  input  logic                            resp_ready,
  // multiplier side
  output logic                            mul_en,
  output logic                            mul_stall,
  output logic [DATA_WIDTH-1:0]           mul_a,
  output logic [DATA_WIDTH-1:0]           mul_b,
  input  logic [OUT_WIDTH-1:0]            mul_out,
  input  logic                            mul_done,
  // occupancy
  output logic [CNT_WIDTH-1:0]            inflight
);

  logic                   w_stall;
  logic                   w_found;
  logic                   w_issue;
  logic                   w_resp_fire;
  logic [ID_WIDTH-1:0]    w_grant_id;
  logic [NUM_REQ-1:0]     w_grant;
  logic [DATA_WIDTH-1:0]  w_mul_a;
  logic [DATA_WIDTH-1:0]  w_mul_b;

  logic [ID_WIDTH-1:0]    r_rr_ptr;
  logic [ID_WIDTH-1:0]    r_tag [DELAY];
  logic [CNT_WIDTH-1:0]   r_inflight;

  // Candidate index k positions after the round-robin pointer, wrapping at NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] ptr,
                                                   input int unsigned k);
    int unsigned sum;
    sum = (32'(ptr) + k) % NUM_REQ;
    return ID_WIDTH'(sum);
  endfunction

  // A result that cannot be delivered freezes the multiplier and all issue.
  assign w_stall     = mul_done && !resp_ready;
  assign w_resp_fire = mul_done && resp_ready;

  // Round-robin search: first valid requester after the last granted one.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_grant    = '0;
    if (!reset && !w_stall) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        if (!w_found && req_valid[rr_index(r_rr_ptr, k)]) begin
          w_found    = 1'b1;
          w_grant_id = rr_index(r_rr_ptr, k);
        end
      end
      if (w_found) begin
        w_grant[w_grant_id] = 1'b1;
      end
    end
  end

  assign w_issue = |(req_valid & w_grant);

  // Operand mux from the granted slice; zero when nothing is issued.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i] && req_valid[i]) begin
        w_mul_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        w_mul_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin pointer moves only on an accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
    end else if (w_issue) begin
      r_rr_ptr <= w_grant_id;
    end
  end

  // Tag pipeline mirrors the multiplier: same depth, same stall, so the tail lines up with mul_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        r_tag[i] <= '0;
      end
    end else if (!w_stall) begin
      r_tag[0] <= w_issue ? w_grant_id : '0;
      for (int unsigned i = 1; i < DELAY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Outstanding-operation counter: issued but not yet accepted at the response port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_resp_fire})
        2'b10:   r_inflight <= r_inflight + CNT_WIDTH'(1);
        2'b01:   r_inflight <= r_inflight - CNT_WIDTH'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign mul_en     = w_issue;
  assign mul_stall  = w_stall;
  assign mul_a      = w_mul_a;
  assign mul_b      = w_mul_b;
  assign resp_valid = mul_done;
  assign resp_data  = mul_out;
  assign resp_id    = r_tag[DELAY-1];
  assign inflight   = r_inflight;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: a behavioural multiplier drives the
// multiplier port, and a queue-based reference model predicts grants,
// operands, response order and occupancy.
module tb_mul_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 16;
  localparam int unsigned DL = 3;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_a, req_b;
  logic [NR-1:0]     req_ready;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [OW-1:0]     resp_data;
  logic              resp_ready;
  logic              mul_en, mul_stall;
  logic [DW-1:0]     mul_a, mul_b;
  logic [OW-1:0]     mul_out;
  logic              mul_done;
  logic [CW-1:0]     inflight;

  always #5 clk = ~clk;

  mul_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .DELAY(DL)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready),
    .mul_en(mul_en), .mul_stall(mul_stall), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .mul_done(mul_done), .inflight(inflight)
  );

  // Q15 product, truncated to the result width.
  function automatic logic [OW-1:0] q15(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    return OW'(p >> 15);
  endfunction

  // Behavioural multiplier: DL-cycle pipeline, frozen by mul_stall, cleared by reset.
  logic [DL-1:0] m_v;
  logic [OW-1:0] m_d [DL];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_v <= '0;
      for (int i = 0; i < int'(DL); i++) m_d[i] <= '0;
    end else if (!mul_stall) begin
      m_v <= {m_v[DL-2:0], mul_en};
      m_d[0] <= q15(mul_a, mul_b);
      for (int i = 1; i < int'(DL); i++) m_d[i] <= m_d[i-1];
    end
  end
  assign mul_done = m_v[DL-1];
  assign mul_out  = m_d[DL-1];

  // Reference model state: ordered list of outstanding operations.
  typedef struct {
    logic [IW-1:0] id;
    logic [OW-1:0] prod;
  } op_t;
  op_t q[$];
  int  m_rr = NR - 1;

  // Drive values for the next cycle.
  logic [NR-1:0]    d_valid = '0;
  logic             d_rready = 1'b1;
  logic             d_rst = 1'b1;
  logic [NR*DW-1:0] d_a = '0, d_b = '0;

  // Values sampled at the check point of the last cycle.
  logic [NR-1:0] s_ready;
  logic          s_rvalid, s_en;
  logic [IW-1:0] s_rid;
  logic [OW-1:0] s_rdata;
  logic [CW-1:0] s_infl;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, check just after, then advance the model.
  task automatic cycle();
    logic [NR-1:0] exp_ready;
    logic          stall;
    int            g, idx;
    op_t           e;
    @(negedge clk);
    reset      = d_rst;
    req_valid  = d_valid;
    resp_ready = d_rready;
    req_a      = d_a;
    req_b      = d_b;
    #1;
    if (d_rst) begin
      q.delete();
      m_rr = NR - 1;
    end
    s_ready = req_ready; s_rvalid = resp_valid; s_en = mul_en;
    s_rid = resp_id; s_rdata = resp_data; s_infl = inflight;

    stall = mul_done && !d_rready;
    g = -1;
    if (!d_rst && !stall) begin
      for (int k = 1; k <= int'(NR); k++) begin
        idx = (m_rr + k) % NR;
        if (g < 0 && d_valid[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("mul_en", 32'(mul_en), 32'(g >= 0));
    check("mul_stall", 32'(mul_stall), 32'(stall));
    check("inflight", 32'(inflight), 32'(q.size()));
    check("resp_valid", 32'(resp_valid), 32'(mul_done));
    if (g >= 0) begin
      check("mul_a", 32'(mul_a), 32'(d_a[g*DW +: DW]));
      check("mul_b", 32'(mul_b), 32'(d_b[g*DW +: DW]));
    end
    if (mul_done) begin
      check("resp_outstanding", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) begin
        check("resp_id", 32'(resp_id), 32'(q[0].id));
        check("resp_data", 32'(resp_data), 32'(q[0].prod));
        if (d_rready) void'(q.pop_front());
      end
    end
    if (g >= 0) begin
      e.id   = IW'(g);
      e.prod = q15(d_a[g*DW +: DW], d_b[g*DW +: DW]);
      q.push_back(e);
      m_rr = g;
    end
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
  } vec_t;
  vec_t tbl [14];

  logic [IW-1:0] hold_id;
  logic [OW-1:0] hold_data;
  logic [CW-1:0] hold_infl;

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;

    // Round-robin vectors starting from reset (pointer at NR-1), resp_ready high.
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b0010, 4'b0010};
    tbl[6]  = '{4'b1010, 4'b1000};
    tbl[7]  = '{4'b1010, 4'b0010};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b0100, 4'b0100};
    tbl[10] = '{4'b0100, 4'b0100};
    tbl[11] = '{4'b0101, 4'b0001};
    tbl[12] = '{4'b1001, 4'b1000};
    tbl[13] = '{4'b0110, 4'b0010};

    d_rst = 1'b1;
    cycle(); cycle();
    check("reset_inflight", 32'(s_infl), 32'(0));
    check("reset_ready", 32'(s_ready), 32'(0));
    check("reset_en", 32'(s_en), 32'(0));
    d_rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      d_valid = tbl[i].valid;
      d_a = {$urandom(), $urandom()};
      d_b = {$urandom(), $urandom()};
      cycle();
      check("tbl_ready", 32'(s_ready), 32'(tbl[i].exp_ready));
    end

    // Drain, then a single Q15 multiply from requester 2.
    d_valid = '0;
    for (int i = 0; i < 5; i++) cycle();
    d_a = '0; d_b = '0;
    d_a[2*DW +: DW] = 16'h4000;
    d_b[2*DW +: DW] = 16'h4000;
    d_valid = 4'b0100;
    cycle();
    check("single_en", 32'(s_en), 32'(1));
    d_valid = '0;
    for (int i = 1; i <= int'(DL); i++) begin
      cycle();
      check("single_inflight", 32'(s_infl), 32'(1));
      check("single_rvalid", 32'(s_rvalid), 32'(i == int'(DL)));
    end
    check("single_rdata", 32'(s_rdata), 32'(16'h2000));
    check("single_rid", 32'(s_rid), 32'(2));
    cycle();
    check("single_inflight_end", 32'(s_infl), 32'(0));

    // Backpressure: hold resp_ready low for 5 cycles while a result waits.
    d_valid = 4'b1111;
    d_a = {$urandom(), $urandom()};
    d_b = {$urandom(), $urandom()};
    s_rvalid = 1'b0;
    for (int i = 0; i < 10 && !s_rvalid; i++) cycle();
    check("stall_reach", 32'(s_rvalid), 32'(1));
    d_rready = 1'b0;
    cycle();
    check("stall_rvalid", 32'(s_rvalid), 32'(1));
    hold_id = s_rid; hold_data = s_rdata; hold_infl = s_infl;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_ready", 32'(s_ready), 32'(0));
      check("stall_rid", 32'(s_rid), 32'(hold_id));
      check("stall_rdata", 32'(s_rdata), 32'(hold_data));
      check("stall_infl", 32'(s_infl), 32'(hold_infl));
    end
    d_rready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // Reset with three operations outstanding.
    d_valid = '0;
    for (int i = 0; i < 5; i++) cycle();
    d_valid = 4'b1111;
    for (int i = 0; i < 3; i++) cycle();
    d_valid = '0;
    cycle();
    check("full_infl", 32'(s_infl), 32'(DL));
    @(negedge clk);
    req_valid = 4'b1111;
    #2;
    reset = 1'b1; d_rst = 1'b1;
    #1;
    check("async_infl", 32'(inflight), 32'(0));
    check("async_ready", 32'(req_ready), 32'(0));
    check("async_en", 32'(mul_en), 32'(0));
    q.delete(); m_rr = NR - 1;
    d_valid = 4'b1111;
    cycle(); cycle();
    d_rst = 1'b0;
    cycle();
    check("post_reset_grant", 32'(s_ready), 32'(4'b0001));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      d_valid  = NR'($urandom());
      d_rready = ($urandom_range(0, 9) < 7);
      d_a      = {$urandom(), $urandom()};
      d_b      = {$urandom(), $urandom()};
      d_rst    = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
